// File: rtl/pl_if_stage.sv
// pl_if_stage: instruction-fetch stage of the 5-stage MIPS pipeline.
// Holds the PC, fetches over a req/ack handshake and loads the IF/ID
// register. A one-entry buffer parks a fetched word across load-use stalls.
// Optional performance counters are built when PL_IF_PERF_CNT_EN is defined;
// otherwise cnt_ifstall and cnt_instr read as constant zero.
module pl_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        nostall,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] da,
  input  logic [31:0] jpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] dpc4,
  output logic [31:0] dinst,
  output logic        ifstall,
  output logic [31:0] cnt_ifstall,
  output logic [31:0] cnt_instr
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ibuf;
  logic [31:0] pc4;
  logic [31:0] npc;
  logic [31:0] word;
  logic        advance;
  logic        park;

  // Handshake outputs derive directly from state, pc and ack.
  assign imem_req  = resetn & (state == FETCH);
  assign imem_addr = pc;
  assign ifstall   = (state == FETCH) & ~imem_ack;

  assign pc4     = pc + 32'd4;
  assign advance = (state == FETCH) ? (imem_ack & nostall) : nostall;
  assign park    = (state == FETCH) & imem_ack & ~nostall;
  assign word    = (state == HOLD) ? ibuf : imem_rdata;

  // Next-PC select from ID; targets are forced word-aligned.
  always_comb begin
    npc = pc4;
    case (pcsource)
      2'b00: npc = pc4;
      2'b01: npc = bpc;
      2'b10: npc = da;
      2'b11: npc = jpc;
      default: npc = pc4;
    endcase
    npc[1:0] = 2'b00;
  end

  // Fetch FSM, PC, holding buffer and IF/ID register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= FETCH;
      pc    <= RESET_PC;
      ibuf  <= '0;
      dinst <= '0;
      dpc4  <= '0;
    end else if (advance) begin
      dinst <= word;
      dpc4  <= pc4;
      pc    <= npc;
      state <= FETCH;
    end else if (park) begin
      ibuf  <= imem_rdata;
      state <= HOLD;
    end
  end

`ifdef PL_IF_PERF_CNT_EN
  // Stall-cycle and fetched-instruction counters, wrapping mod 2^32.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_ifstall <= '0;
      cnt_instr   <= '0;
    end else begin
      if (ifstall) cnt_ifstall <= cnt_ifstall + 32'd1;
      if (advance) cnt_instr   <= cnt_instr + 32'd1;
    end
  end
`else
  assign cnt_ifstall = '0;
  assign cnt_instr   = '0;
`endif

endmodule

// File: tb/tb_pl_if_stage.sv
// Self-checking bench for pl_if_stage: hand-derived vector table, wait-state
// and reset-during-fetch sequences, then randomized traffic against a
// behavioural model of the fetch rules.
module tb_pl_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] B0 = 32'hBBBB_0000;
  localparam logic [31:0] D0 = 32'hDDDD_0000;
  localparam logic [31:0] J0 = 32'hEEEE_0000;

  logic        clock;
  logic        resetn;
  logic        nostall;
  logic [1:0]  pcsource;
  logic [31:0] bpc, da, jpc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] dpc4, dinst;
  logic        ifstall;
  logic [31:0] cnt_ifstall, cnt_instr;

  pl_if_stage #(.RESET_PC(RESET_PC)) dut (
    .clock(clock), .resetn(resetn), .nostall(nostall), .pcsource(pcsource),
    .bpc(bpc), .da(da), .jpc(jpc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .dpc4(dpc4), .dinst(dinst),
    .ifstall(ifstall), .cnt_ifstall(cnt_ifstall), .cnt_instr(cnt_instr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: architectural PC, IF/ID contents, parked words, counters.
  logic [31:0] m_pc, m_dpc4, m_dinst, m_cs, m_ci;
  logic [31:0] m_park[$];
  bit          addr_data;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (addr_data) return a;
    return a ^ {a[15:0], a[31:16]} ^ 32'hC001_D00D;
  endfunction

  function automatic logic [31:0] exp_cnt(input logic [31:0] v);
`ifdef PL_IF_PERF_CNT_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_dpc4 = '0; m_dinst = '0; m_cs = '0; m_ci = '0;
    m_park.delete();
  endtask

  // Drive one cycle's inputs and compare outputs against the model mid-cycle.
  task automatic apply(input logic ns, input logic [1:0] ps, input logic [31:0] b,
                       input logic [31:0] d, input logic [31:0] j, input logic ack);
    nostall = ns; pcsource = ps; bpc = b; da = d; jpc = j; imem_ack = ack;
    imem_rdata = (m_park.size() != 0) ? $urandom : mem_word(m_pc);
    @(negedge clock);
    chk("m_req",     32'(imem_req), 32'(m_park.size() == 0));
    chk("m_addr",    imem_addr, m_pc);
    chk("m_ifstall", 32'(ifstall), 32'((m_park.size() == 0) && !ack));
    chk("m_dpc4",    dpc4, m_dpc4);
    chk("m_dinst",   dinst, m_dinst);
    chk("m_cnt_stall", cnt_ifstall, exp_cnt(m_cs));
    chk("m_cnt_instr", cnt_instr, exp_cnt(m_ci));
  endtask

  // Apply the spec's update rules to the model and move to the next cycle.
  task automatic finish();
    logic [31:0] tgt;
    case (pcsource)
      2'd0: tgt = m_pc + 32'd4;
      2'd1: tgt = bpc;
      2'd2: tgt = da;
      default: tgt = jpc;
    endcase
    tgt = tgt & ~32'd3;
    if (m_park.size() != 0) begin
      if (nostall) begin
        m_dinst = m_park.pop_front();
        m_dpc4 = m_pc + 32'd4; m_pc = tgt; m_ci++;
      end
    end else if (!imem_ack) begin
      m_cs++;
    end else if (nostall) begin
      m_dinst = mem_word(m_pc);
      m_dpc4 = m_pc + 32'd4; m_pc = tgt; m_ci++;
    end else begin
      m_park.push_back(mem_word(m_pc));
    end
    @(posedge clock);
    #1;
  endtask

  task automatic step(input logic ns, input logic [1:0] ps, input logic [31:0] b,
                      input logic [31:0] d, input logic [31:0] j, input logic ack);
    apply(ns, ps, b, d, j, ack);
    finish();
  endtask

  // Assert reset mid-cycle, check reset values, release just after an edge.
  task automatic do_reset();
    resetn = 1'b0; imem_ack = 1'b0;
    #1;
    chk("rst_req",   32'(imem_req), 32'd0);
    chk("rst_addr",  imem_addr, RESET_PC);
    chk("rst_dinst", dinst, 32'd0);
    chk("rst_dpc4",  dpc4, 32'd0);
    chk("rst_cnt_stall", cnt_ifstall, 32'd0);
    chk("rst_cnt_instr", cnt_instr, 32'd0);
    model_reset();
    @(posedge clock); @(posedge clock); #1;
    resetn = 1'b1;
  endtask

  typedef struct {
    logic        ns;
    logic [1:0]  ps;
    logic [31:0] b, d, j;
    logic        ack;
    logic [31:0] e_addr;
    logic        e_req, e_ifst;
    logic [31:0] e_dpc4, e_dinst;
  } vec_t;

  function automatic vec_t mk(input logic ns, input logic [1:0] ps, input logic [31:0] b,
                              input logic [31:0] d, input logic [31:0] j, input logic ack,
                              input logic [31:0] ea, input logic er, input logic ei,
                              input logic [31:0] ep4, input logic [31:0] edi);
    vec_t v;
    v.ns = ns; v.ps = ps; v.b = b; v.d = d; v.j = j; v.ack = ack;
    v.e_addr = ea; v.e_req = er; v.e_ifst = ei; v.e_dpc4 = ep4; v.e_dinst = edi;
    return v;
  endfunction

  vec_t tbl[19];

  initial begin
    resetn = 1'b0; nostall = 1'b1; pcsource = 2'd0;
    bpc = B0; da = D0; jpc = J0; imem_ack = 1'b0; imem_rdata = '0;
    addr_data = 1'b1;
    model_reset();

    // Expected outputs seen during each row, before that row's edge.
    tbl[0]  = mk(1, 0, B0, D0, J0, 1, 32'h00, 1, 0, 32'h00, 32'h00);
    tbl[1]  = mk(1, 0, B0, D0, J0, 1, 32'h04, 1, 0, 32'h04, 32'h00);
    tbl[2]  = mk(1, 0, B0, D0, J0, 1, 32'h08, 1, 0, 32'h08, 32'h04);
    tbl[3]  = mk(1, 0, B0, D0, J0, 1, 32'h0C, 1, 0, 32'h0C, 32'h08);
    tbl[4]  = mk(0, 0, B0, D0, J0, 1, 32'h10, 1, 0, 32'h10, 32'h0C);
    tbl[5]  = mk(0, 0, B0, D0, J0, 1, 32'h10, 0, 0, 32'h10, 32'h0C);
    tbl[6]  = mk(1, 0, B0, D0, J0, 0, 32'h10, 0, 0, 32'h10, 32'h0C);
    tbl[7]  = mk(1, 0, B0, D0, J0, 1, 32'h14, 1, 0, 32'h14, 32'h10);
    tbl[8]  = mk(1, 0, B0, D0, J0, 0, 32'h18, 1, 1, 32'h18, 32'h14);
    tbl[9]  = mk(1, 0, B0, D0, J0, 1, 32'h18, 1, 0, 32'h18, 32'h14);
    tbl[10] = mk(1, 0, B0, D0, J0, 1, 32'h1C, 1, 0, 32'h1C, 32'h18);
    tbl[11] = mk(1, 0, B0, D0, J0, 1, 32'h20, 1, 0, 32'h20, 32'h1C);
    tbl[12] = mk(1, 1, 32'h100, D0, J0, 1, 32'h24, 1, 0, 32'h24, 32'h20);
    tbl[13] = mk(1, 0, B0, D0, J0, 1, 32'h100, 1, 0, 32'h28, 32'h24);
    tbl[14] = mk(1, 2, B0, 32'h203, J0, 1, 32'h104, 1, 0, 32'h104, 32'h100);
    tbl[15] = mk(1, 3, B0, D0, 32'h3FF, 1, 32'h200, 1, 0, 32'h108, 32'h104);
    tbl[16] = mk(1, 3, B0, D0, 32'hFFFF_FFFF, 1, 32'h3FC, 1, 0, 32'h204, 32'h200);
    tbl[17] = mk(1, 0, B0, D0, J0, 1, 32'hFFFF_FFFC, 1, 0, 32'h400, 32'h3FC);
    tbl[18] = mk(1, 0, B0, D0, J0, 0, 32'h00, 1, 1, 32'h00, 32'hFFFF_FFFC);

    @(posedge clock); #1;
    do_reset();
    foreach (tbl[i]) begin
      apply(tbl[i].ns, tbl[i].ps, tbl[i].b, tbl[i].d, tbl[i].j, tbl[i].ack);
      chk($sformatf("t%0d_addr", i),    imem_addr, tbl[i].e_addr);
      chk($sformatf("t%0d_req", i),     32'(imem_req), 32'(tbl[i].e_req));
      chk($sformatf("t%0d_ifstall", i), 32'(ifstall), 32'(tbl[i].e_ifst));
      chk($sformatf("t%0d_dpc4", i),    dpc4, tbl[i].e_dpc4);
      chk($sformatf("t%0d_dinst", i),   dinst, tbl[i].e_dinst);
      finish();
    end

    // Three wait states per fetch, four fetches.
    do_reset();
    for (int f = 0; f < 4; f++) begin
      for (int w = 0; w < 3; w++) begin
        apply(1, 0, B0, D0, J0, 0);
        chk("ws_ifstall", 32'(ifstall), 32'd1);
        finish();
      end
      apply(1, 0, B0, D0, J0, 1);
      chk("ws_addr", imem_addr, 32'(4 * f));
      chk("ws_ack_ifstall", 32'(ifstall), 32'd0);
      finish();
    end
    apply(1, 0, B0, D0, J0, 0);
    chk("ws_cnt_instr", cnt_instr, exp_cnt(32'd4));
    chk("ws_cnt_stall", cnt_ifstall, exp_cnt(32'd12));
    chk("ws_dpc4", dpc4, 32'h10);
    finish();

    // Reset while a fetch at 0x40 is waiting on memory.
    do_reset();
    step(1, 3, B0, D0, 32'h40, 1);
    apply(1, 0, B0, D0, J0, 0);
    chk("mid_addr", imem_addr, 32'h40);
    chk("mid_ifstall", 32'(ifstall), 32'd1);
    do_reset();
    apply(1, 0, B0, D0, J0, 1);
    chk("post_rst_addr", imem_addr, RESET_PC);
    chk("post_rst_req", 32'(imem_req), 32'd1);
    finish();

    // Randomized traffic against the model.
    addr_data = 1'b0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
